// File: rtl/output_cmd_queue.sv
// output_cmd_queue
//   Single-clock FIFO holding packet transmit commands for one egress
//   interface. The tag-match/packet-table lookup path writes it and the
//   per-interface transmit sequencer drains it. Command word layout:
//   {empty[2:0], in_iface[1:0], start_addr[13:0], length[7:0]}.
//
//   Read data is registered and non-showahead: q updates on the edge that
//   accepts a read and holds its value otherwise.
//
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   sclr     synchronous clear, active high (wins over wrreq/rdreq)
//   wrreq    write request; dropped while full
//   data     write data
//   rdreq    read request; ignored while empty
//   q        registered read data
//   empty    queue holds no entries
//   full     queue holds DEPTH entries
//   usedw    occupancy, 0..DEPTH (only with OUTPUT_CMD_QUEUE_USEDW_EN)
//
// Build option:
//   OUTPUT_CMD_QUEUE_USEDW_EN  adds the usedw occupancy output.

module output_cmd_queue #(
    parameter  int WIDTH = 27,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             sclr,
    input  logic             wrreq,
    input  logic [WIDTH-1:0] data,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
`ifdef OUTPUT_CMD_QUEUE_USEDW_EN
    output logic [AW:0]      usedw,
`endif
    output logic             empty,
    output logic             full
);

    // Pointers carry one extra wrap bit so that equal indices can be told
    // apart as "empty" (same lap) or "full" (one lap apart).
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic wr_accept;
    logic rd_accept;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);

    // sclr suppresses both accepts, so a write in the clearing cycle is
    // neither stored nor counted.
    assign wr_accept = wrreq && !full  && !sclr;
    assign rd_accept = rdreq && !empty && !sclr;

`ifdef OUTPUT_CMD_QUEUE_USEDW_EN
    // Modulo subtraction of the wrap-bit pointers yields 0..DEPTH directly.
    assign usedw = wr_ptr - rd_ptr;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q      <= '0;
        end else if (sclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q      <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
                q      <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and a resettable array would not map to RAM.
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            mem[wr_ptr[AW-1:0]] <= data;
        end
    end

endmodule

// File: tb/tb_output_cmd_queue.sv
// tb_output_cmd_queue
//   Directed bench for output_cmd_queue. The stimulus process keeps a queue
//   model of the FIFO contents; whenever it issues a read the model says
//   will be accepted, it pushes the expected word into a scoreboard. A
//   separate monitor pops and compares q on the falling edge after each
//   such read. Flags (and usedw when built in) are compared against the
//   model after every cycle.

module tb_output_cmd_queue;

    localparam int WIDTH = 27;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);

    logic             clock;
    logic             reset_n;
    logic             sclr;
    logic             wrreq;
    logic [WIDTH-1:0] data;
    logic             rdreq;
    logic [WIDTH-1:0] q;
    logic             empty;
    logic             full;
`ifdef OUTPUT_CMD_QUEUE_USEDW_EN
    logic [AW:0]      usedw;
`endif

    output_cmd_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .sclr    (sclr),
        .wrreq   (wrreq),
        .data    (data),
        .rdreq   (rdreq),
        .q       (q),
`ifdef OUTPUT_CMD_QUEUE_USEDW_EN
        .usedw   (usedw),
`endif
        .empty   (empty),
        .full    (full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;

    logic [WIDTH-1:0] model_q [$];   // expected FIFO contents
    logic [WIDTH-1:0] sb_q    [$];   // expected q values, one per accepted read
    logic [WIDTH-1:0] last_q;        // expected value held on q
    logic             rd_tick = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a read accepted at a rising edge presents its word on q, which
    // is compared at the following falling edge.
    initial begin
        logic due;
        forever begin
            @(posedge clock);
            due = rd_tick;
            @(negedge clock);
            if (due) begin
                if (sb_q.size() == 0) begin
                    check("sb_underrun", 32'd1, 32'd0);
                end else begin
                    check("q_data", 32'(q), 32'(sb_q.pop_front()));
                end
            end
        end
    end

    task automatic check_flags(input string tag);
        check({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
        check({tag, "_full"},  32'(full),  32'(model_q.size() == DEPTH));
`ifdef OUTPUT_CMD_QUEUE_USEDW_EN
        check({tag, "_usedw"}, 32'(usedw), 32'(model_q.size()));
`endif
    endtask

    // One clock cycle of stimulus, entered and left just after a falling edge.
    task automatic step(input logic wr, input logic [WIDTH-1:0] d,
                        input logic rd, input logic sc, input string tag);
        logic wr_acc;
        logic rd_acc;
        wr_acc = wr && (model_q.size() < DEPTH) && !sc;
        rd_acc = rd && (model_q.size() > 0) && !sc;
        wrreq  = wr;
        data   = d;
        rdreq  = rd;
        sclr   = sc;
        if (rd_acc) begin
            sb_q.push_back(model_q[0]);
        end
        rd_tick = rd_acc;
        @(posedge clock);
        if (sc) begin
            model_q.delete();
            last_q = '0;
        end else begin
            if (rd_acc) last_q = model_q.pop_front();
            if (wr_acc) model_q.push_back(d);
        end
        #1;
        wrreq   = 1'b0;
        rdreq   = 1'b0;
        sclr    = 1'b0;
        rd_tick = 1'b0;
        @(negedge clock);
        check_flags(tag);
    endtask

    task automatic do_write(input logic [WIDTH-1:0] d);
        step(1'b1, d, 1'b0, 1'b0, "wr");
    endtask

    task automatic do_read();
        step(1'b0, '0, 1'b1, 1'b0, "rd");
    endtask

    logic [WIDTH-1:0] pat;

    initial begin
        reset_n = 1'b0;
        sclr    = 1'b0;
        wrreq   = 1'b0;
        rdreq   = 1'b0;
        data    = '0;
        last_q  = '0;
        repeat (2) @(negedge clock);
        check("reset_q", 32'(q), 32'h0);
        check_flags("reset");
        reset_n = 1'b1;
        @(negedge clock);

        // Reset mid-operation: q holds a real word before reset hits.
        do_write(27'h0000AAA);
        do_write(27'h0000BBB);
        do_write(27'h0000CCC);
        do_read();
        check("pre_reset_q", 32'(q), 32'h0000AAA);
        #2 reset_n = 1'b0;
        #1;
        model_q.delete();
        last_q = '0;
        check("async_rst_q", 32'(q), 32'h0);
        check_flags("async_rst");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        step(1'b0, '0, 1'b1, 1'b0, "rst_rd");
        check("rst_rd_q", 32'(q), 32'h0);

        // Fill to full, drop an overflow write, drain in order.
        for (int i = 1; i <= DEPTH; i++) do_write(WIDTH'(i));
        check("fill_full", 32'(full), 32'h1);
        do_write(27'h7FFFFFF);
        for (int i = 1; i <= DEPTH; i++) do_read();
        check("drain_empty", 32'(empty), 32'h1);
        check("drain_last_q", 32'(q), 32'h20);

        // Underflow: q holds the last read word.
        do_write(27'h1234567);
        do_read();
        for (int i = 0; i < 3; i++) begin
            do_read();
            check("underflow_q", 32'(q), 32'h1234567);
        end

        // Concurrent read/write at steady occupancy 5.
        for (int i = 0; i < 5; i++) do_write(WIDTH'(27'h0100000 + i));
        for (int i = 0; i < 10; i++) step(1'b1, WIDTH'(27'h0200000 + i), 1'b1, 1'b0, "conc");
        // Fill up, then concurrent access while full: write dropped.
        while (model_q.size() < DEPTH) do_write(WIDTH'(27'h0300000 + model_q.size()));
        step(1'b1, 27'h5555555, 1'b1, 1'b0, "conc_full");
        check("conc_full_flag", 32'(full), 32'h0);
        while (model_q.size() > 0) do_read();

        // Write into an empty queue alongside rdreq: read ignored, not forwarded.
        step(1'b1, 27'h0ABCDEF, 1'b1, 1'b0, "wr_empty_rd");
        check("no_forward_q", 32'(q), 32'(last_q));
        do_read();

        // Three fill/drain laps with distinct patterns across pointer wrap.
        for (int lap = 0; lap < 3; lap++) begin
            for (int i = 0; i < DEPTH; i++) begin
                pat = WIDTH'((lap + 1) * 27'h0111111) ^ WIDTH'(i * 37);
                do_write(pat);
            end
            for (int i = 0; i < DEPTH; i++) do_read();
        end

        // Synchronous clear with a concurrent write.
        for (int i = 0; i < 7; i++) do_write(WIDTH'(27'h0700000 + i));
        do_read();
        check("pre_sclr_q", 32'(q), 32'h0700000);
        step(1'b1, 27'h0DEAD00, 1'b0, 1'b1, "sclr");
        check("sclr_q", 32'(q), 32'h0);
        do_read();
        check("sclr_rd_q", 32'(q), 32'h0);
        do_write(27'h0000042);
        do_read();

        repeat (2) @(negedge clock);
        check("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Watchdog: the directed sequence is a few hundred cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/output_cmd_queue.md
Name: output_cmd_queue

Overview:
- Synchronous single-clock FIFO holding packet transmit commands for one egress interface.
- Command word layout (27 b): {empty[2:0], in_iface[1:0], start_addr[13:0], length[7:0]}.
- Written by the tag-match/packet-table lookup path and drained by the per-interface transmit sequencer.
- One instance per output interface, so lookups are never blocked by a busy transmitter.

Parameters:
- WIDTH, 27, data word width in bits.
- DEPTH, 32, number of entries; must be a power of two, minimum 2.
- AW, $clog2(DEPTH), address width (derived, not overridden).

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- sclr  input  1  synchronous clear, active high.
- wrreq  input  1  write request.
- data  input  WIDTH  write data.
- rdreq  input  1  read request.
- q  output  WIDTH  read data, registered.
- empty  output  1  FIFO holds 0 entries.
- full  output  1  FIFO holds DEPTH entries.

Behaviour:
- Storage: DEPTH x WIDTH array. Write and read pointers are AW+1 bits wide (extra wrap bit).
  - empty = pointers equal.
  - full = low AW bits equal and MSBs differ.
  - Both flags are combinational from registered pointers.
- Reset (reset_n low, asynchronous):
  - pointers = 0, q = 0, empty = 1, full = 0.
  - Array contents are not reset.
- sclr (sampled on a clock edge, reset_n high):
  - Same result as reset: pointers = 0, q = 0.
  - Overrides wrreq/rdreq in that cycle.
  - Aborts any in-progress activity.
- Write accept = wrreq && !full.
  - data is stored at wr_ptr; wr_ptr increments on that edge.
  - wrreq while full is dropped silently. The pointer and contents are unchanged.
  - A write is dropped when full even if rdreq is accepted in the same cycle.
- Read accept = rdreq && !empty.
  - On that edge q <= mem[rd_ptr] and rd_ptr increments.
  - q is valid in the cycle after rdreq is asserted (1-cycle latency, non-showahead).
  - q holds its last value when no read is accepted.
  - rdreq while empty is ignored: q and pointer are unchanged.
- Simultaneous accepted read and write: both pointers advance and the occupancy is unchanged.
  - Write while empty plus rdreq: the read is ignored (empty was 1) and the write is accepted. empty deasserts next cycle; the word is not forwarded to q.
- Pointers wrap modulo 2*DEPTH. The array index is the low AW bits.
- Ordering is strict FIFO. No data is reordered or duplicated.
- Occupancy never exceeds DEPTH and never goes below 0 under any stimulus.

Optional Feature:
- Macro OUTPUT_CMD_QUEUE_USEDW_EN.
- When defined:
  - Adds output port usedw, AW+1 bits = wr_ptr - rd_ptr (0..DEPTH).
  - usedw is combinational from the pointers.
  - usedw is 0 after reset or sclr.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset/flags: assert reset_n=0 mid-operation after 3 writes -> immediately empty=1, full=0, q=0. After release, rdreq gives no change.
- Fill/order: write 0x0000001..0x0000020 (32 words, DEPTH=32) -> full=1 after the 32nd edge. A 33rd write of 0x7FFFFFF is dropped. 32 reads return 0x0000001..0x0000020 in order, each on q one cycle after rdreq. empty=1 after the last read.
- Underflow: rdreq held 3 cycles while empty with q=0x1234567 from the prior read -> q stays 0x1234567, empty stays 1.
- Concurrent: with 5 entries, assert wrreq+rdreq for 10 cycles -> occupancy stays 5 (usedw=5 when enabled) and the outputs follow write order. When full, concurrent wrreq+rdreq -> read accepted, write dropped, full=0 next cycle.
- Wrap: 3 full fill/drain cycles of 32 words with distinct patterns -> all data correct across pointer wrap.
- sclr: with 7 entries, assert sclr with wrreq=1 -> next cycle empty=1, q=0, write not stored.
